// File: rtl/seven_segment_capture.sv
// seven_segment_capture: rebuilds hex number, dots and glyph validity from a multiplexed seven-segment scan bus
module seven_segment_capture #(
    parameter int w_digit          = 8,
    parameter int stable_cycles    = 4,
    parameter int timeout_cycles   = 1048576,
    parameter int seg_active_low   = 0,
    parameter int digit_active_low = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           abcdefgh,
    input  logic [w_digit-1:0]   digit,
    output logic [w_digit*4-1:0] number,
    output logic [w_digit-1:0]   dots,
    output logic [w_digit-1:0]   digit_valid,
    output logic                 frame_done,
    output logic                 stale
);
    localparam int tw = $clog2(timeout_cycles + 1);
    typedef enum logic [1:0] {WAIT_SEL, SETTLE, HOLD} state_t;
    state_t state, state_nx;
    logic [7:0] seg_r, seg_l, cnt;
    logic [w_digit-1:0] dig_r, sel_l, sh_dot, sh_dot_nx, sh_val, sh_val_nx, seen, seen_nx;
    logic [w_digit*4-1:0] sh_num, sh_num_nx;
    logic [tw-1:0] idle;
    logic [4:0] dec;
    logic onehot, same, cap, full;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E: decode = 5'h10;
            7'h30: decode = 5'h11;
            7'h6D: decode = 5'h12;
            7'h79: decode = 5'h13;
            7'h33: decode = 5'h14;
            7'h5B: decode = 5'h15;
            7'h5F: decode = 5'h16;
            7'h70: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h7B: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h1F: decode = 5'h1B;
            7'h4E: decode = 5'h1C;
            7'h3D: decode = 5'h1D;
            7'h4F: decode = 5'h1E;
            7'h47: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign dec    = decode(seg_l[7:1]);
    assign onehot = (dig_r != '0) && ((dig_r & (dig_r - 1'b1)) == '0);
    assign same   = (dig_r == sel_l) && (seg_r == seg_l);
    assign stale  = (idle == tw'(timeout_cycles));

    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        case (state)
            WAIT_SEL: state_nx = onehot ? SETTLE : WAIT_SEL;
            SETTLE: begin
                cap      = same && (cnt >= 8'(stable_cycles - 1));
                state_nx = !same ? WAIT_SEL : (cap ? HOLD : SETTLE);
            end
            HOLD:    state_nx = (dig_r != sel_l) ? WAIT_SEL : HOLD;
            default: state_nx = WAIT_SEL;
        endcase
    end

    // Shadow copy seen by the frame-complete transfer includes the capture happening this cycle
    always_comb begin
        sh_num_nx = sh_num;
        sh_dot_nx = sh_dot;
        sh_val_nx = sh_val;
        for (int i = 0; i < w_digit; i++)
            if (cap && sel_l[i]) begin
                sh_num_nx[i*4 +: 4] = dec[3:0];
                sh_dot_nx[i]        = seg_l[0];
                sh_val_nx[i]        = dec[4];
            end
        seen_nx = cap ? (seen | sel_l) : seen;
        full    = cap && (&seen_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r       <= '0;
            dig_r       <= '0;
            state       <= WAIT_SEL;
            seg_l       <= '0;
            sel_l       <= '0;
            cnt         <= '0;
            sh_num      <= '0;
            sh_dot      <= '0;
            sh_val      <= '0;
            seen        <= '0;
            idle        <= '0;
            number      <= '0;
            dots        <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
        end else begin
            seg_r  <= (seg_active_low != 0) ? ~abcdefgh : abcdefgh;
            dig_r  <= (digit_active_low != 0) ? ~digit : digit;
            state  <= state_nx;
            sh_num <= sh_num_nx;
            sh_dot <= sh_dot_nx;
            sh_val <= sh_val_nx;
            if (state == WAIT_SEL && onehot) begin
                sel_l <= dig_r;
                seg_l <= seg_r;
                cnt   <= 8'd1;
            end else if (state == SETTLE && same && cnt != 8'hFF)
                cnt <= cnt + 8'd1;
            if (cap)
                idle <= '0;
            else if (!stale)
                idle <= idle + 1'b1;
            frame_done <= full;
            seen       <= full ? '0 : seen_nx;
            if (full) begin
                number      <= sh_num_nx;
                dots        <= sh_dot_nx;
                digit_valid <= sh_val_nx;
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: directed checks of scan capture, framing, reset, stale and inverted-bus decode
module tb_seven_segment_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] abcdefgh = '0;
    logic [7:0] digit = '0;
    logic [31:0] number_a, number_b;
    logic [7:0] dots_a, dots_b, valid_a, valid_b;
    logic fd_a, fd_b, stale_a, stale_b;
    int checks = 0, failures = 0, fd_cnt = 0, fd_base;
    logic [6:0] g [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    logic [31:0] v;

    always #5 clk = ~clk;

    seven_segment_capture #(.timeout_cycles(200)) dut_a (
        .clk(clk), .rst(rst), .abcdefgh(abcdefgh), .digit(digit),
        .number(number_a), .dots(dots_a), .digit_valid(valid_a),
        .frame_done(fd_a), .stale(stale_a)
    );

    seven_segment_capture #(.timeout_cycles(200), .seg_active_low(1), .digit_active_low(1)) dut_b (
        .clk(clk), .rst(rst), .abcdefgh(~abcdefgh), .digit(~digit),
        .number(number_b), .dots(dots_b), .digit_valid(valid_b),
        .frame_done(fd_b), .stale(stale_b)
    );

    always @(negedge clk) if (fd_a) fd_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show_raw(input int i, input logic [7:0] seg, input int n);
        digit    = 8'(1 << i);
        abcdefgh = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int i, input logic [3:0] nib, input logic dot, input int n);
        show_raw(i, {g[nib], dot}, n);
    endtask

    task automatic idle(input int n);
        digit    = '0;
        abcdefgh = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_number", number_a, 0);
        chk("rst_dots", dots_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_fd", fd_a, 0);
        chk("rst_stale", stale_a, 0);
        chk("rst_number_b", number_b, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        fd_base = fd_cnt;
        v = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) show(i, v[i*4 +: 4], 8'hA5 >> i, 8);
        idle(3);
        @(negedge clk);
        chk("f1_fd", fd_cnt, fd_base + 1);
        chk("f1_number", number_a, 32'hDEADBEEF);
        chk("f1_dots", dots_a, 8'hA5);
        chk("f1_valid", valid_a, 8'hFF);
        chk("f1_number_b", number_b, 32'hDEADBEEF);
        chk("f1_dots_b", dots_b, 8'hA5);
        #1;

        fd_base = fd_cnt;
        v = 32'h76543210;
        for (int i = 0; i < 8; i++)
            if (i == 2) show_raw(i, 8'h02, 8);
            else show(i, v[i*4 +: 4], 1'b0, 8);
        idle(3);
        @(negedge clk);
        chk("bad_fd", fd_cnt, fd_base + 1);
        chk("bad_number", number_a, 32'h76543010);
        chk("bad_valid", valid_a, 8'hFB);
        chk("bad_dots", dots_a, 8'h00);
        #1;

        fd_base = fd_cnt;
        v = 32'h89ABCDEF;
        show(3, 4'h5, 1'b1, 3);
        for (int i = 0; i < 8; i++) if (i != 3) show(i, v[i*4 +: 4], 1'b0, 8);
        idle(3);
        @(negedge clk);
        chk("short_fd", fd_cnt, fd_base);
        chk("short_number", number_a, 32'h76543010);
        #1;
        show(3, 4'hC, 1'b1, 8);
        idle(3);
        @(negedge clk);
        chk("short_fd2", fd_cnt, fd_base + 1);
        chk("short_number2", number_a, 32'h89ABCDEF);
        chk("short_dots2", dots_a, 8'h08);
        chk("short_valid2", valid_a, 8'hFF);
        #1;

        fd_base = fd_cnt;
        v = 32'h01234567;
        show(0, 4'h4, 1'b0, 8);
        for (int i = 1; i < 7; i++) show(i, v[i*4 +: 4], 1'b0, 8);
        show(0, 4'h7, 1'b0, 8);
        show(7, 4'h0, 1'b0, 8);
        idle(3);
        @(negedge clk);
        chk("inv_fd", fd_cnt, fd_base + 1);
        chk("inv_number_a", number_a, 32'h01234567);
        chk("inv_number_b", number_b, 32'h01234567);
        chk("inv_valid_b", valid_b, 8'hFF);
        chk("inv_dots_b", dots_b, 8'h00);
        #1;

        fd_base = fd_cnt;
        for (int i = 0; i < 5; i++) show(i, 4'h9, 1'b1, 8);
        show(5, 4'h9, 1'b1, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_number", number_a, 0);
        chk("mid_rst_dots", dots_a, 0);
        chk("mid_rst_valid", valid_a, 0);
        chk("mid_rst_number_b", number_b, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        v = 32'h13579BDF;
        for (int i = 5; i < 8; i++) show(i, v[i*4 +: 4], 1'b0, 8);
        idle(3);
        @(negedge clk);
        chk("post_rst_no_fd", fd_cnt, fd_base);
        chk("post_rst_number", number_a, 0);
        #1;
        for (int i = 0; i < 5; i++) show(i, v[i*4 +: 4], 1'b0, 8);
        idle(3);
        @(negedge clk);
        chk("post_rst_fd", fd_cnt, fd_base + 1);
        chk("post_rst_number2", number_a, 32'h13579BDF);
        chk("post_rst_valid2", valid_a, 8'hFF);
        chk("post_rst_dots2", dots_a, 8'h00);
        #1;

        fd_base = fd_cnt;
        digit    = 8'h03;
        abcdefgh = {g[0], 1'b0};
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stale_early", stale_a, 0);
        repeat (210) @(posedge clk);
        @(negedge clk);
        chk("stale_a", stale_a, 1);
        chk("stale_b", stale_b, 1);
        chk("stale_number", number_a, 32'h13579BDF);
        chk("stale_fd", fd_cnt, fd_base);
        #1;
        show(0, 4'h1, 1'b0, 8);
        @(negedge clk);
        chk("stale_clear", stale_a, 0);
        chk("stale_clear_number", number_a, 32'h13579BDF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seven_segment_capture.md
SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Purpose: receive-side monitor for the multiplexed seven-segment scan bus; reconstructs hex number and dots from abcdefgh/digit.

Interface
REQ-001 SHALL have parameter w_digit, default 8, number of multiplexed digits.
REQ-002 SHALL have parameter stable_cycles, default 4, cycles a select/segment pair must hold before capture (1..255).
REQ-003 SHALL have parameter timeout_cycles, default 1048576, idle cycles before stale asserts.
REQ-004 SHALL have parameter seg_active_low, default 0, 1 = segment bits inverted on the bus.
REQ-005 SHALL have parameter digit_active_low, default 0, 1 = digit selects inverted on the bus.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 abcdefgh  input  8  segment bus, bit7=a ... bit1=g, bit0=h (dot).
REQ-009 digit  input  w_digit  digit select, bit i = digit i.
REQ-010 number  output  w_digit*4  decoded hex, nibble i = digit i.
REQ-011 dots  output  w_digit  captured dot per digit.
REQ-012 digit_valid  output  w_digit  1 = last capture of digit i was a legal hex glyph.
REQ-013 frame_done  output  1  one-cycle pulse when outputs update.
REQ-014 stale  output  1  no capture for timeout_cycles.

Function
REQ-015 SHALL normalise inputs first (invert per seg_active_low/digit_active_low); all later rules use normalised active-high values.
REQ-016 SHALL register both inputs once (one-stage input register) before any decision; treat inputs as synchronous to clk.
REQ-017 FSM states WAIT_SEL, SETTLE, HOLD; reset state WAIT_SEL.
REQ-018 WAIT_SEL: exactly one select bit high -> SETTLE, latch select and segments, stability counter=1; zero or multiple bits -> stay.
REQ-019 SETTLE: select and segments equal latched values -> counter+1; counter reaching stable_cycles -> capture, go HOLD; any change -> WAIT_SEL, no capture.
REQ-020 HOLD: stay while select unchanged (segment changes ignored); select change -> WAIT_SEL.
REQ-021 Capture of digit i SHALL write shadow nibble i, shadow dot i (=h), shadow valid i, and set seen bit i.
REQ-022 Decode of bits[7:1] SHALL be: 0=7E,1=30,2=6D,3=79,4=33,5=5B,6=5F,7=70,8=7F,9=7B,A=77,b=1F,C=4E,d=3D,E=4F,F=47 (7-bit a..g values); any other pattern -> nibble 0, valid 0.
REQ-023 When all w_digit seen bits are 1 (including the capture in progress), SHALL copy shadow to number/dots/digit_valid, pulse frame_done for exactly that cycle, clear all seen bits the same cycle.
REQ-024 Recapture of a digit before frame completes SHALL overwrite its shadow entry; seen unchanged.
REQ-025 Outputs SHALL change only on frame_done cycles; latency from capture completing last digit to frame_done = 1 cycle.
REQ-026 Idle counter SHALL reset on every capture, saturate at timeout_cycles; stale = (counter == timeout_cycles); first subsequent capture clears stale next cycle.
REQ-027 Counters SHALL saturate, never wrap.

Reset
REQ-028 On rst: number=0, dots=0, digit_valid=0, frame_done=0, stale=0, shadow/seen/counters=0, FSM=WAIT_SEL, input register=0.
REQ-029 rst asserted mid-SETTLE or mid-frame SHALL discard partial data; no frame_done on release.

Verification
REQ-030 Drive the team's seven_segment_display with number=32'hDEADBEEF, dots=8'hA5 -> within one full scan + 2 cycles frame_done pulses, number=DEADBEEF, dots=A5, digit_valid=FF.
REQ-031 Select digit 3 for stable_cycles-1 cycles then switch -> no capture of digit 3, no frame_done.
REQ-032 Digit 2 shows pattern 7'h01 (g only), others legal -> nibble 2 = 0, digit_valid=8'hFB.
REQ-033 Drive digit=8'h03 (two bits) indefinitely -> no capture; stale after timeout_cycles, outputs unchanged.
REQ-034 seg_active_low=1, digit_active_low=1, inverted bus for 0x01234567 -> number=01234567.
REQ-035 Assert rst after 5 of 8 digits captured -> all outputs 0; next frame_done only after 8 fresh captures.
